// File: rtl/i2c_axil_pkg.sv
// Shared definitions for the I2C AXI-Lite register front-end: register word indices,
// CTRL/STATUS bit positions, AXI response codes and a byte-strobe merge helper.
package i2c_axil_pkg;

    // Register word index, taken from addr[4:2]
    typedef enum logic [2:0] {
        RegCtrl   = 3'd0,
        RegTxdata = 3'd1,
        RegRxdata = 3'd2,
        RegStatus = 3'd3,
        RegIe     = 3'd4
    } reg_idx_e;

    localparam int unsigned CTRL_START   = 31;

    localparam int unsigned STATUS_BUSY  = 0;
    localparam int unsigned STATUS_DONE  = 1;
    localparam int unsigned STATUS_START = 2;
    localparam int unsigned STATUS_ERR   = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new_val into old_val for every byte lane whose strobe is set
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/i2c_axil_wr_chan.sv
// AXI-Lite write channel: captures AW and W independently, issues a one-cycle commit
// strobe once both halves are held, and runs the B handshake. One write outstanding.
module i2c_axil_wr_chan
    import i2c_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [31:0]       commit_data,
    output logic [3:0]        commit_strb,
    input  logic [1:0]        commit_resp
);

    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // Holding registers stay full until the B handshake, which blocks a second write
    assign s_awready   = ~rst & ~aw_held_q;
    assign s_wready    = ~rst & ~w_held_q;
    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign commit      = aw_held_q & w_held_q & ~bvalid_q;
    assign commit_addr = aw_addr_q;
    assign commit_data = w_data_q;
    assign commit_strb = w_strb_q;

    // Next-state for capture, response and release
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (s_awvalid && s_awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_held_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = commit_resp;
        end
        if (bvalid_q && s_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    // State registers; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/i2c_axil_regs.sv
// AXI-Lite register front-end for the I2C master core: CTRL/TXDATA drive the core's command
// words, RXDATA snapshots its read result on the done edge, STATUS reports busy/done/err.
// Define I2C_AXIL_IRQ_EN to add the IE register at 0x10 and the registered irq output.
module i2c_axil_regs
    import i2c_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       i2c_data0,
    output logic [31:0]       i2c_data1,
    input  logic [31:0]       i2c_data2,
    input  logic              i2c_busy,
    input  logic              i2c_done
`ifdef I2C_AXIL_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic              commit;
    logic [ADDR_W-1:0] commit_addr;
    logic [31:0]       commit_data;
    logic [3:0]        commit_strb;
    logic [1:0]        commit_resp;

    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic        done_st_q, done_st_d;
    logic        err_q, err_d;
    logic        done_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
`ifdef I2C_AXIL_IRQ_EN
    logic [1:0]  ie_q, ie_d;
    logic        irq_q, irq_d;
`endif

    logic [7:0]  wa_ext, ra_ext;
    reg_idx_e    wr_idx, rd_idx;
    logic        done_rise;
    logic        reg_locked;
    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic        unused_addr;

    i2c_axil_wr_chan #(
        .ADDR_W (ADDR_W)
    ) u_wr_chan (
        .clk         (clk),
        .rst         (rst),
        .s_awaddr    (s_awaddr),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .commit_resp (commit_resp)
    );

    // Word index from addr[4:2]; with a 4-bit address 0x10 is simply unreachable
    assign wa_ext      = 8'(commit_addr);
    assign ra_ext      = 8'(s_araddr);
    assign wr_idx      = reg_idx_e'(wa_ext[4:2]);
    assign rd_idx      = reg_idx_e'(ra_ext[4:2]);
    assign unused_addr = ^{wa_ext[7:5], wa_ext[1:0], ra_ext[7:5], ra_ext[1:0]};

    assign done_rise   = i2c_done & ~done_q;
    assign reg_locked  = i2c_busy | ctrl_q[CTRL_START];
    assign status_word = {28'd0, err_q, ctrl_q[CTRL_START], done_st_q, i2c_busy};

    assign i2c_data0 = ctrl_q;
    assign i2c_data1 = tx_q;
    assign s_arready = ~rst & ~rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = RESP_OKAY;
`ifdef I2C_AXIL_IRQ_EN
    assign irq       = irq_q;
`endif

    // Register writes, then hardware updates so the done edge and sticky sets win
    always_comb begin
        ctrl_d      = ctrl_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        done_st_d   = done_st_q;
        err_d       = err_q;
        commit_resp = RESP_OKAY;
`ifdef I2C_AXIL_IRQ_EN
        ie_d        = ie_q;
`endif
        if (commit) begin
            case (wr_idx)
                RegCtrl: begin
                    if (reg_locked) commit_resp = RESP_SLVERR;
                    else            ctrl_d = apply_strb(ctrl_q, commit_data, commit_strb);
                end
                RegTxdata: begin
                    if (reg_locked) commit_resp = RESP_SLVERR;
                    else            tx_d = apply_strb(tx_q, commit_data, commit_strb);
                end
                RegStatus: begin
                    if (commit_strb[0] && commit_data[STATUS_DONE]) done_st_d = 1'b0;
                    if (commit_strb[0] && commit_data[STATUS_ERR])  err_d     = 1'b0;
                end
`ifdef I2C_AXIL_IRQ_EN
                RegIe: begin
                    if (commit_strb[0]) ie_d = commit_data[1:0];
                end
`endif
                default: ;
            endcase
        end
        if (commit_resp == RESP_SLVERR) err_d = 1'b1;
        if (done_rise) begin
            ctrl_d[CTRL_START] = 1'b0;
            rx_d               = i2c_data2;
            done_st_d          = 1'b1;
        end
    end

`ifdef I2C_AXIL_IRQ_EN
    // irq follows the next STATUS/IE values so it rises together with STATUS.done
    always_comb begin
        irq_d = (done_st_d & ie_d[0]) | (err_d & ie_d[1]);
    end
`endif

    // Read mux over current register values
    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            RegCtrl:   rd_mux = ctrl_q;
            RegTxdata: rd_mux = tx_q;
            RegRxdata: rd_mux = rx_q;
            RegStatus: rd_mux = status_word;
`ifdef I2C_AXIL_IRQ_EN
            RegIe:     rd_mux = {30'd0, ie_q};
`endif
            default:   rd_mux = 32'd0;
        endcase
    end

    // Read channel: load data on AR handshake, hold until R handshake
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (s_arvalid && s_arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            done_st_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
`ifdef I2C_AXIL_IRQ_EN
            ie_q      <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            done_st_q <= done_st_d;
            err_q     <= err_d;
            done_q    <= i2c_done;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
`ifdef I2C_AXIL_IRQ_EN
            ie_q      <= ie_d;
            irq_q     <= irq_d;
`endif
        end
    end

endmodule
